multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised multicycle control unit for the basic microprocessor. Owns its own
//  FETCH/DECODE/EXEC/MEM/WB state register, instruction register and PC, handshakes
//  with instruction/data memory, and drives ALU op, writeback select and write enables.
//  Supports add, sub, beq, lw and sw. Any other opcode traps.
// PARAMETERS
//  XLEN      32  datapath, instruction, PC and immediate width
//  ALU_OP_W  3   width of alu_op
//  PC_RESET  0   PC value after reset
//  PC_STEP   4   sequential PC increment
// PORTS
//  clk        in   1         system clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  instr_in   in   XLEN      fetched instruction word, valid when mem_ready=1 in FETCH
//  mem_ready  in   1         memory access complete (fetch or data) this cycle
//  alu_zero   in   1         ALU zero flag, sampled in EXEC
//  imm        in   XLEN      sign-extended branch offset from the decoder
//  ir         out  XLEN      instruction register
//  pc         out  XLEN      program counter
//  mem_req    out  1         memory request (FETCH, MEM)
//  mem_we     out  1         data write strobe (MEM and sw only)
//  alu_op     out  ALU_OP_W  000=add, 001=sub/compare(beq), 010=sub
//  wb_sel     out  2         00=ALU result, 01=load data
//  reg_we     out  1         register-file write enable, one cycle in WB
//  stage      out  5         one-hot {WB,MEM,EXEC,DECODE,FETCH}; all zero in TRAP
//  illegal    out  1         sticky illegal-opcode flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH, pc=PC_RESET, ir=0, alu_op=0, wb_sel=0,
//    illegal=0. Combinational outputs then read mem_req=1, mem_we=0, reg_we=0,
//    stage=00001.
//  - Release of rst_n is synchronous to clk. Reset asserted mid-instruction aborts it;
//    no reg_we/mem_we pulse is produced.
//  - mem_req, mem_we, reg_we and stage are decoded from the registered state (and ir)
//    only. ir, pc, alu_op, wb_sel and illegal are registered.
//  - Opcode = ir[6:0]: 0110011 R-type (ir[30]=0 add, 1 sub), 1100011 beq,
//    0000011 lw, 0100011 sw.
//  - FETCH: mem_req=1. Stay while mem_ready=0. On mem_ready=1: ir<=instr_in, go DECODE.
//  - DECODE: legal opcode -> set alu_op and wb_sel, go EXEC.
//    alu_op: add/lw/sw 000, beq 001, sub 010. wb_sel: lw 01, others 00.
//    Illegal opcode -> illegal<=1, go TRAP.
//  - EXEC: R-type -> WB. lw/sw -> MEM.
//    beq -> pc<=pc+imm if alu_zero else pc+PC_STEP, then go FETCH.
//  - MEM: mem_req=1; mem_we=1 only for sw. Stay while mem_ready=0.
//    On mem_ready=1: lw -> WB; sw -> pc<=pc+PC_STEP, go FETCH.
//  - WB: reg_we=1 for exactly one cycle, pc<=pc+PC_STEP, go FETCH.
//  - TRAP: all strobes 0, stage=0, pc and ir frozen. Only rst_n exits TRAP.
//  - PC arithmetic is modulo 2^XLEN. pc+PC_STEP from all-ones-minus-3 wraps to 0.
//    Negative imm wraps the same way.
//  - Cycles per instruction with zero-wait memory: R-type 4, lw 5, sw 4, beq 3.
//    Each mem_ready=0 cycle in FETCH or MEM adds one cycle.
//  - mem_ready outside FETCH/MEM is ignored. imm and alu_zero are ignored outside EXEC.
// TESTING
//  1. Reset: hold rst_n=0 over edges -> pc=0, stage=00001, mem_req=1, reg_we=0,
//     illegal=0. Assert rst_n mid-MEM of sw -> mem_we drops immediately, state=FETCH.
//  2. add (0x002081B3), mem_ready=1 always -> stage 01,02,04,10,01; alu_op=000;
//     reg_we=1 on the 4th cycle only; pc 0->4.
//  3. lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_we=0,
//     wb_sel=01, reg_we pulse after ready, pc +4; total 8 cycles.
//  4. beq at pc=0x10, imm=0xFFFFFFF8: alu_zero=1 -> pc=0x08; alu_zero=0 -> pc=0x14;
//     3 cycles each, no reg_we or mem_we.
//  5. sw with fetch stalled 2 cycles -> ir unchanged until ready; mem_we=1 only in
//     MEM; pc +4; reg_we never set.
//  6. Opcode 0x7F -> illegal=1, stage=0, mem_req=0; pc frozen for 10 cycles until
//     rst_n=0. PC wrap: pc=0xFFFFFFFC add -> pc=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with its own IR and PC.
// Supports add, sub, beq, lw and sw; any other opcode parks the unit in TRAP until reset.
module multicycle_ctrl_fsm #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     ALU_OP_W = 3,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [XLEN-1:0]     instr_in,
    input  logic                mem_ready,
    input  logic                alu_zero,
    input  logic [XLEN-1:0]     imm,
    output logic [XLEN-1:0]     ir,
    output logic [XLEN-1:0]     pc,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          wb_sel,
    output logic                reg_we,
    output logic [4:0]          stage,
    output logic                illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_BEQ = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2);

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    state_e                state_q, state_d;
    logic [XLEN-1:0]       ir_q, ir_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [1:0]            wb_sel_q, wb_sel_d;
    logic                  illegal_q, illegal_d;
    logic [6:0]            opcode;

    assign opcode = ir_q[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            pc_q      <= PC_RESET;
            alu_op_q  <= '0;
            wb_sel_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            alu_op_q  <= alu_op_d;
            wb_sel_q  <= wb_sel_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        alu_op_d  = alu_op_q;
        wb_sel_d  = wb_sel_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d  = S_EXEC;
                wb_sel_d = WB_ALU;
                case (opcode)
                    OP_RTYPE: alu_op_d = ir_q[30] ? ALU_SUB : ALU_ADD;
                    OP_BEQ:   alu_op_d = ALU_BEQ;
                    OP_LW: begin
                        alu_op_d = ALU_ADD;
                        wb_sel_d = WB_LOAD;
                    end
                    OP_SW:    alu_op_d = ALU_ADD;
                    default: begin
                        wb_sel_d  = wb_sel_q;
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        pc_d    = alu_zero ? (pc_q + imm) : (pc_q + STEP);
                        state_d = S_FETCH;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_q + STEP;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_q + STEP;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes depend only on registered state and IR so they are glitch-free per cycle.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        reg_we  = 1'b0;
        stage   = 5'b00000;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                stage   = 5'b00001;
            end
            S_DECODE: stage = 5'b00010;
            S_EXEC:   stage = 5'b00100;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_SW);
                stage   = 5'b01000;
            end
            S_WB: begin
                reg_we = 1'b1;
                stage  = 5'b10000;
            end
            default: stage = 5'b00000;
        endcase
    end

    assign ir      = ir_q;
    assign pc      = pc_q;
    assign alu_op  = alu_op_q;
    assign wb_sel  = wb_sel_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised bench for multicycle_ctrl_fsm: a per-instruction stage timeline is built from
// the instruction class and stall counts, then every cycle is compared against it.
module tb_multicycle_ctrl_fsm;

    localparam logic [4:0] ST_FETCH  = 5'b00001;
    localparam logic [4:0] ST_DECODE = 5'b00010;
    localparam logic [4:0] ST_EXEC   = 5'b00100;
    localparam logic [4:0] ST_MEM    = 5'b01000;
    localparam logic [4:0] ST_WB     = 5'b10000;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        mem_ready;
    logic        alu_zero;
    logic [31:0] imm;
    logic [31:0] ir;
    logic [31:0] pc;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  alu_op;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [4:0]  stage;
    logic        illegal;

    int          n_checks;
    int          n_errors;
    logic [31:0] model_pc;
    logic [31:0] model_ir;
    logic [5:0]  exp_q[$];

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr_in  (instr_in),
        .mem_ready (mem_ready),
        .alu_zero  (alu_zero),
        .imm       (imm),
        .ir        (ir),
        .pc        (pc),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .reg_we    (reg_we),
        .stage     (stage),
        .illegal   (illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_alu(input logic [31:0] ins);
        if (ins[6:0] == OP_R) return ins[30] ? 3'b010 : 3'b000;
        if (ins[6:0] == OP_BEQ) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [31:0] make_instr(input logic [6:0] op, input logic sub);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = op;
        if (op == OP_R) w[31:25] = {1'b0, sub, 5'b0};
        return w;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_pc = 32'h0;
        model_ir = 32'h0;
    endtask

    // Drives one instruction through the DUT and checks each cycle against the timeline.
    task automatic run_instr(input logic [31:0] ins, input int fs, input int ms,
                             input logic zero, input logic [31:0] immv);
        logic [6:0]  op;
        logic [31:0] next_pc;
        logic [5:0]  e;
        logic [4:0]  st;
        logic        rdy;
        op = ins[6:0];
        exp_q.delete();
        for (int i = 0; i <= fs; i++) exp_q.push_back({(i == fs), ST_FETCH});
        exp_q.push_back({1'b0, ST_DECODE});
        exp_q.push_back({1'b0, ST_EXEC});
        if (op == OP_LW || op == OP_SW)
            for (int i = 0; i <= ms; i++) exp_q.push_back({(i == ms), ST_MEM});
        if (op == OP_R || op == OP_LW) exp_q.push_back({1'b0, ST_WB});
        next_pc = (op == OP_BEQ && zero) ? model_pc + immv : model_pc + 32'd4;

        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            st  = e[4:0];
            rdy = e[5];
            check("stage", 32'(stage), 32'(st));
            check("mem_req", 32'(mem_req), 32'(st == ST_FETCH || st == ST_MEM));
            check("mem_we", 32'(mem_we), 32'(st == ST_MEM && op == OP_SW));
            check("reg_we", 32'(reg_we), 32'(st == ST_WB));
            check("pc_hold", pc, model_pc);
            check("ir", ir, (st == ST_FETCH) ? model_ir : ins);
            if (st == ST_EXEC || st == ST_MEM || st == ST_WB) begin
                check("alu_op", 32'(alu_op), 32'(exp_alu(ins)));
                check("wb_sel", 32'(wb_sel), (op == OP_LW) ? 32'd1 : 32'd0);
            end
            mem_ready = (st == ST_FETCH || st == ST_MEM) ? rdy : 1'($urandom);
            instr_in  = (st == ST_FETCH && rdy) ? ins : $urandom;
            alu_zero  = (st == ST_EXEC) ? zero : 1'($urandom);
            imm       = (st == ST_EXEC) ? immv : $urandom;
            tick();
        end
        model_pc = next_pc;
        model_ir = ins;
        check("end_stage", 32'(stage), 32'(ST_FETCH));
        check("end_pc", pc, model_pc);
        check("illegal", 32'(illegal), 32'd0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  ops[4];
        int          k;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        instr_in  = 32'h0;
        mem_ready = 1'b1;
        alu_zero  = 1'b0;
        imm       = 32'h0;
        ops[0] = OP_R; ops[1] = OP_BEQ; ops[2] = OP_LW; ops[3] = OP_SW;

        // reset held over several edges with inputs toggling
        for (int i = 0; i < 3; i++) begin
            instr_in  = $urandom;
            mem_ready = 1'($urandom);
            tick();
        end
        check("rst_pc", pc, 32'h0);
        check("rst_stage", 32'(stage), 32'(ST_FETCH));
        check("rst_mem_req", 32'(mem_req), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_ir", ir, 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_wb_sel", 32'(wb_sel), 32'd0);
        rst_n    = 1'b1;
        model_pc = 32'h0;
        model_ir = 32'h0;

        run_instr(32'h002081B3, 0, 0, 1'b0, 32'h0);
        check("add_pc4", pc, 32'h4);
        run_instr(make_instr(OP_LW, 1'b0), 0, 3, 1'b0, 32'h0);
        check("lw_pc8", pc, 32'h8);
        run_instr(make_instr(OP_R, 1'b0), 0, 0, 1'b0, 32'h0);
        run_instr(make_instr(OP_R, 1'b1), 0, 0, 1'b0, 32'h0);
        run_instr(make_instr(OP_BEQ, 1'b0), 0, 0, 1'b1, 32'hFFFF_FFF8);
        check("beq_taken", pc, 32'h8);
        run_instr(make_instr(OP_R, 1'b0), 1, 0, 1'b0, 32'h0);
        run_instr(make_instr(OP_R, 1'b1), 0, 0, 1'b0, 32'h0);
        run_instr(make_instr(OP_BEQ, 1'b0), 0, 0, 1'b0, 32'hFFFF_FFF8);
        check("beq_not_taken", pc, 32'h14);
        run_instr(make_instr(OP_SW, 1'b0), 2, 0, 1'b0, 32'h0);
        check("sw_pc", pc, 32'h18);

        for (int n = 0; n < 60; n++) begin
            k   = $urandom_range(0, 3);
            ins = make_instr(ops[k], 1'($urandom));
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                      {$urandom_range(0, 32'h3FFF), 2'b00});
        end

        // PC wrap: branch to all-ones-minus-3, then an add must land on zero
        run_instr(make_instr(OP_BEQ, 1'b0), 0, 0, 1'b1, 32'hFFFF_FFFC - model_pc);
        check("pre_wrap_pc", pc, 32'hFFFF_FFFC);
        run_instr(make_instr(OP_R, 1'b0), 0, 0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        run_instr(make_instr(OP_R, 1'b0), 0, 0, 1'b0, 32'h0);

        // reset asserted mid-MEM of a store
        ins       = make_instr(OP_SW, 1'b0);
        mem_ready = 1'b1;
        instr_in  = ins;
        tick();
        tick();
        tick();
        check("sw_in_mem", 32'(stage), 32'(ST_MEM));
        check("sw_mem_we", 32'(mem_we), 32'd1);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_stage", 32'(stage), 32'(ST_FETCH));
        check("abort_mem_req", 32'(mem_req), 32'd1);
        check("abort_ir", ir, 32'h0);
        check("abort_pc", pc, 32'h0);
        tick();
        check("abort_reg_we", 32'(reg_we), 32'd0);
        rst_n    = 1'b1;
        model_pc = 32'h0;
        model_ir = 32'h0;
        run_instr(make_instr(OP_R, 1'b0), 0, 0, 1'b0, 32'h0);
        run_instr(make_instr(OP_R, 1'b1), 0, 0, 1'b0, 32'h0);

        // illegal opcode traps and freezes pc/ir until reset
        check("pre_trap_stage", 32'(stage), 32'(ST_FETCH));
        mem_ready = 1'b1;
        instr_in  = 32'h0000_007F;
        tick();
        check("trap_decode", 32'(stage), 32'(ST_DECODE));
        instr_in = $urandom;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("trap_illegal", 32'(illegal), 32'd1);
            check("trap_stage", 32'(stage), 32'd0);
            check("trap_mem_req", 32'(mem_req), 32'd0);
            check("trap_strobes", {30'd0, mem_we, reg_we}, 32'd0);
            check("trap_pc", pc, 32'h8);
            check("trap_ir", ir, 32'h0000_007F);
            mem_ready = 1'($urandom);
            instr_in  = $urandom;
            alu_zero  = 1'($urandom);
            imm       = $urandom;
            tick();
        end
        apply_reset();
        check("post_trap_illegal", 32'(illegal), 32'd0);
        check("post_trap_stage", 32'(stage), 32'(ST_FETCH));
        check("post_trap_pc", pc, 32'h0);
        run_instr(make_instr(OP_LW, 1'b0), 1, 1, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
